// File: rtl/dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_arbiter
// Description : Round-robin two-port arbiter in front of the single-ported
//               16x32 data RAM; returns read data with a 1-cycle valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstN,
    // requester A
    input  logic              reqA,
    input  logic              rwA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] wdataA,
    output logic              gntA,
    output logic              rvalidA,
    output logic [DATA_W-1:0] rdataA,
    // requester B
    input  logic              reqB,
    input  logic              rwB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] wdataB,
    output logic              gntB,
    output logic              rvalidB,
    output logic [DATA_W-1:0] rdataB,
    // RAM command bus
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramRw,
    output logic [DATA_W-1:0] ramDataIn,
    input  logic [DATA_W-1:0] ramDataOut
);

    localparam logic c_GNT_A = 1'b0;
    localparam logic c_GNT_B = 1'b1;

    logic r_last_gnt;
    logic r_pend_a;
    logic r_pend_b;
    logic w_gnt_a;
    logic w_gnt_b;

    // Under contention the requester that did not win last time goes next.
    assign w_gnt_a = rstN & reqA & (~reqB | (r_last_gnt == c_GNT_B));
    assign w_gnt_b = rstN & reqB & (~reqA | (r_last_gnt == c_GNT_A));

    assign gntA = w_gnt_a;
    assign gntB = w_gnt_b;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_last_gnt <= c_GNT_B;
            r_pend_a   <= 1'b0;
            r_pend_b   <= 1'b0;
        end else begin
            if (w_gnt_a) begin
                r_last_gnt <= c_GNT_A;
            end else if (w_gnt_b) begin
                r_last_gnt <= c_GNT_B;
            end
            r_pend_a <= w_gnt_a & rwA;
            r_pend_b <= w_gnt_b & rwB;
        end
    end

    // Idle bus parks in read mode so nothing can be written by accident.
    always_comb begin
        ramAddr   = '0;
        ramRw     = 1'b1;
        ramDataIn = '0;
        if (w_gnt_a) begin
            ramAddr   = addrA;
            ramRw     = rwA;
            ramDataIn = wdataA;
        end else if (w_gnt_b) begin
            ramAddr   = addrB;
            ramRw     = rwB;
            ramDataIn = wdataB;
        end
    end

    // Gating with rstN drops a read that was in flight when reset arrived.
    assign rvalidA = r_pend_a & rstN;
    assign rvalidB = r_pend_b & rstN;
    assign rdataA  = rvalidA ? ramDataOut : '0;
    assign rdataB  = rvalidB ? ramDataOut : '0;

endmodule
`default_nettype wire

// File: tb/tb_dram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_arbiter
// Description : Directed self-checking bench for dram_arbiter with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_arbiter;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstN;
    logic              reqA, rwA, reqB, rwB;
    logic [ADDR_W-1:0] addrA, addrB;
    logic [DATA_W-1:0] wdataA, wdataB;
    logic              gntA, gntB, rvalidA, rvalidB;
    logic [DATA_W-1:0] rdataA, rdataB;
    logic [ADDR_W-1:0] ramAddr;
    logic              ramRw;
    logic [DATA_W-1:0] ramDataIn;
    logic [DATA_W-1:0] ramDataOut;

    logic [DATA_W-1:0] mem [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstN(rstN),
        .reqA(reqA), .rwA(rwA), .addrA(addrA), .wdataA(wdataA),
        .gntA(gntA), .rvalidA(rvalidA), .rdataA(rdataA),
        .reqB(reqB), .rwB(rwB), .addrB(addrB), .wdataB(wdataB),
        .gntB(gntB), .rvalidB(rvalidB), .rdataB(rdataB),
        .ramAddr(ramAddr), .ramRw(ramRw), .ramDataIn(ramDataIn),
        .ramDataOut(ramDataOut)
    );

    // genram2 model: write at the edge, registered read data
    always @(posedge clk) begin
        if (!ramRw) mem[ramAddr] <= ramDataIn;
        ramDataOut <= mem[ramAddr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // advance one edge, then let inputs settle away from it
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        mem[3] = 32'hDEAD_BEEF;
        ramDataOut = '0;
        rstN = 1'b0;
        reqA = 0; rwA = 1; addrA = '0; wdataA = '0;
        reqB = 0; rwB = 1; addrB = '0; wdataB = '0;
        cyc(); cyc();
        #1;
        chk("rst_gntA", {31'b0, gntA}, 32'd0);
        chk("rst_gntB", {31'b0, gntB}, 32'd0);
        chk("rst_rvalidA", {31'b0, rvalidA}, 32'd0);
        chk("rst_rvalidB", {31'b0, rvalidB}, 32'd0);
        chk("rst_rdataA", rdataA, 32'd0);
        chk("rst_ramRw", {31'b0, ramRw}, 32'd1);
        chk("rst_ramAddr", {28'b0, ramAddr}, 32'd0);
        chk("rst_ramDataIn", ramDataIn, 32'd0);

        // 1: single A read of addr 3
        rstN = 1; reqA = 1; rwA = 1; addrA = 4'd3;
        #1;
        chk("t1_gntA", {31'b0, gntA}, 32'd1);
        chk("t1_gntB", {31'b0, gntB}, 32'd0);
        chk("t1_ramAddr", {28'b0, ramAddr}, 32'd3);
        chk("t1_ramRw", {31'b0, ramRw}, 32'd1);
        cyc();
        reqA = 0;
        // 2: B write addr 5 in the same cycle A's read returns
        reqB = 1; rwB = 0; addrB = 4'd5; wdataB = 32'h1234_5678;
        #1;
        chk("t1_rvalidA", {31'b0, rvalidA}, 32'd1);
        chk("t1_rdataA", rdataA, 32'hDEAD_BEEF);
        chk("t1_rvalidB", {31'b0, rvalidB}, 32'd0);
        chk("t2_gntB", {31'b0, gntB}, 32'd1);
        chk("t2_ramRw", {31'b0, ramRw}, 32'd0);
        chk("t2_ramAddr", {28'b0, ramAddr}, 32'd5);
        chk("t2_ramDataIn", ramDataIn, 32'h1234_5678);
        cyc();
        reqB = 0; rwB = 1;
        reqA = 1; rwA = 1; addrA = 4'd5;
        #1;
        chk("t2_gntA", {31'b0, gntA}, 32'd1);
        chk("t2_wr_no_rvalidB", {31'b0, rvalidB}, 32'd0);
        cyc();
        reqA = 0;
        #1;
        chk("t2_rvalidA", {31'b0, rvalidA}, 32'd1);
        chk("t2_rdataA", rdataA, 32'h1234_5678);

        // 3: continuous contention right after reset
        rstN = 0;
        cyc(); cyc();
        rstN = 1;
        reqA = 1; rwA = 1; addrA = 4'd1;
        reqB = 1; rwB = 1; addrB = 4'd2;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("t3_gntA_%0d", k), {31'b0, gntA}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("t3_gntB_%0d", k), {31'b0, gntB}, (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k > 0) begin
                chk($sformatf("t3_rvalidA_%0d", k), {31'b0, rvalidA}, (k % 2 == 1) ? 32'd1 : 32'd0);
                chk($sformatf("t3_rdataA_%0d", k), rdataA, (k % 2 == 1) ? 32'h1000_0001 : 32'd0);
                chk($sformatf("t3_rdataB_%0d", k), rdataB, (k % 2 == 0) ? 32'h1000_0002 : 32'd0);
            end
            cyc();
        end
        reqA = 0; reqB = 0;
        #1;
        chk("t3_last_rvalidB", {31'b0, rvalidB}, 32'd1);
        chk("t3_last_rdataB", rdataB, 32'h1000_0002);

        // 4: A alone on addr 7, then contention favours B
        reqA = 1; rwA = 1; addrA = 4'd7;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t4_gntA_%0d", k), {31'b0, gntA}, 32'd1);
            cyc();
        end
        reqB = 1; rwB = 1; addrB = 4'd3;
        #1;
        chk("t4_contend_gntB", {31'b0, gntB}, 32'd1);
        chk("t4_contend_gntA", {31'b0, gntA}, 32'd0);
        chk("t4_rvalidA", {31'b0, rvalidA}, 32'd1);
        chk("t4_rdataA", rdataA, 32'h1000_0007);
        cyc();
        reqA = 0; reqB = 0;
        #1;
        chk("t4_rdataB", rdataB, 32'hDEAD_BEEF);

        // 5: A read granted, then reset with both requesting
        reqA = 1; rwA = 1; addrA = 4'd4;
        #1;
        chk("t5_gntA", {31'b0, gntA}, 32'd1);
        cyc();
        rstN = 0; reqB = 1; rwB = 1; addrB = 4'd6;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("t5_rst_gntA_%0d", k), {31'b0, gntA}, 32'd0);
            chk($sformatf("t5_rst_gntB_%0d", k), {31'b0, gntB}, 32'd0);
            chk($sformatf("t5_rst_rvalidA_%0d", k), {31'b0, rvalidA}, 32'd0);
            chk($sformatf("t5_rst_ramRw_%0d", k), {31'b0, ramRw}, 32'd1);
            cyc();
        end
        rstN = 1;
        #1;
        chk("t5_post_gntA", {31'b0, gntA}, 32'd1);
        chk("t5_post_gntB", {31'b0, gntB}, 32'd0);
        chk("t5_post_rvalidA", {31'b0, rvalidA}, 32'd0);
        cyc();
        reqA = 0; reqB = 0;
        #1;
        chk("t5_rvalidA", {31'b0, rvalidA}, 32'd1);
        chk("t5_rdataA", rdataA, 32'h1000_0004);

        // 6: idle bus, then readback of earlier contents
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("t6_ramRw_%0d", k), {31'b0, ramRw}, 32'd1);
            chk($sformatf("t6_ramAddr_%0d", k), {28'b0, ramAddr}, 32'd0);
            chk($sformatf("t6_gnt_%0d", k), {30'b0, gntA, gntB}, 32'd0);
            chk($sformatf("t6_rvalid_%0d", k), {30'b0, rvalidA, rvalidB}, 32'd0);
        end
        reqB = 1; rwB = 1; addrB = 4'd5;
        cyc();
        addrB = 4'd3;
        #1;
        chk("t6_rb5", rdataB, 32'h1234_5678);
        cyc();
        reqB = 0;
        addrB = 4'd0;
        #1;
        chk("t6_rb3", rdataB, 32'hDEAD_BEEF);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-port arbiter sharing the single-ported data RAM (genram2: 16 x 32, one `rw` line) between requester A (CPU datapath load/store) and requester B (debug/loader port for preloading or inspecting data memory).
- Grants one access per cycle, round-robin under contention.
- Drives the RAM command bus; steers registered read data back to the requester whose read was granted, with a valid strobe.
- Sits between the datapath's aluResult/rd_data2/data_out nets and the genram2 instance.

Parameters:
ADDR_W, 4, RAM word-address width
DATA_W, 32, RAM data width

Ports:
clk  in  1  system clock, rising edge
rstN  in  1  synchronous reset, active-low
reqA  in  1  requester A access request; held until gntA
rwA  in  1  A direction: 1 = read, 0 = write (same sense as RAM rw)
addrA  in  ADDR_W  A word address
wdataA  in  DATA_W  A write data
gntA  out  1  A request accepted this cycle
rvalidA  out  1  rdataA carries A's read result
rdataA  out  DATA_W  A read data
reqB  in  1  requester B request
rwB  in  1  B direction, same encoding
addrB  in  ADDR_W  B word address
wdataB  in  DATA_W  B write data
gntB  out  1  B request accepted
rvalidB  out  1  rdataB valid
rdataB  out  DATA_W  B read data
ramAddr  out  ADDR_W  to RAM addr
ramRw  out  1  to RAM rw (1 = read, 0 = write)
ramDataIn  out  DATA_W  to RAM data_in
ramDataOut  in  DATA_W  from RAM data_out

Behaviour:
- RAM contract:
  - Write commits at the rising edge where ramRw = 0.
  - Read data appears on ramDataOut the cycle after the address is presented (1-cycle latency).
- Grant (combinational, same cycle as request):
  - Only reqA → gntA.
  - Only reqB → gntB.
  - Both → grant the requester NOT in register lastGnt.
  - gntA and gntB are never both 1.
  - While rstN = 0, both grants are forced to 0.
- lastGnt register:
  - Updates on every grant to the granted requester.
  - Holds when there is no grant.
  - Reset value = B, so A wins the first contention.
- RAM bus:
  - Granted requester's addr/rw/wdata are muxed onto ramAddr/ramRw/ramDataIn in the same cycle.
  - No grant (or in reset): ramAddr = 0, ramRw = 1, ramDataIn = 0, so no write can occur.
- Read return:
  - Registers pendA/pendB are set at an edge where the corresponding grant is a read (rw = 1); otherwise cleared.
  - rvalidX = pendX.
  - rdataX = ramDataOut when pendX, else 0.
  - Total read latency is 1 cycle from grant to rvalid.
  - Writes produce no response.
- Back-to-back: a requester may be granted every cycle when uncontended; reads pipeline at 1 per cycle.
- Contention: A and B alternate grants every cycle. Maximum wait for either requester is 1 cycle, so no starvation.
- Hazards:
  - Same-cycle read/write to one address by different requesters is impossible (only one grant).
  - Read in cycle N+1 after a write in cycle N returns the new data (RAM write-first at edge).
  - No forwarding or buffering inside the arbiter.
- Requester rule: reqX with changing addr/rw/wdata before gntX is a protocol violation. Behaviour is unspecified, but the arbiter must still never double-grant.
- Reset:
  - At any edge with rstN = 0: pendA = pendB = 0 and lastGnt = B.
  - A read granted in the cycle before reset asserts is dropped; rvalid stays 0.
  - Outputs after reset: gntA/gntB = 0 (no requests), rvalidA/B = 0, rdataA/B = 0, ramRw = 1, ramAddr = 0, ramDataIn = 0.

Test Plan:
1. Reset, then reqA read addr 3 (RAM[3] = 0xDEADBEEF) → gntA same cycle, ramAddr = 3, ramRw = 1; next cycle rvalidA = 1, rdataA = 0xDEADBEEF, rvalidB = 0.
2. reqB write addr 5 data 0x12345678, then reqA read addr 5 next cycle → gntB, ramRw = 0; then gntA; following cycle rdataA = 0x12345678.
3. reqA and reqB both read continuously for 6 cycles right after reset → grant sequence A, B, A, B, A, B; rvalid alternates A/B one cycle later with the correct per-address data.
4. reqA read addr 7 alone for 4 cycles → gntA every cycle, rvalidA high on cycles 2-5, lastGnt = A; then both request → B granted first.
5. Grant an A read, drop rstN on the next cycle for 2 cycles while both request → gntA = gntB = 0 during reset, rvalidA never asserts, ramRw = 1; after release, first contention grants A.
6. No requests for 5 cycles → ramRw = 1, ramAddr = 0, all gnt/rvalid = 0, and RAM contents unchanged (readback check).
